// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  // Instruction word width.
  localparam int INSTR_W = 32;

  // Canonical NOP (addi x0,x0,0) loaded into the IR at reset.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  // Fetch controller states: IDLE waits for a request, WAIT is the ROM data cycle.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/instr_fetch_if.sv
// Handshake / ROM bus bundle between the control FSM, the ROM and the fetch stage.
interface instr_fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 17
);

  logic                fetch_req;
  logic                fetch_ack;
  logic                redirect;
  logic [ADDR_W-1:0]   redirect_target;
  logic [ADDR_W-1:0]   rom_addr;
  logic [INSTR_W-1:0]  rom_data;
  logic [INSTR_W-1:0]  ir;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   pc_plus4;
  logic                misalign;

  // Controller / ROM side.
  modport master (
    output fetch_req,
    output redirect,
    output redirect_target,
    output rom_data,
    input  fetch_ack,
    input  rom_addr,
    input  ir,
    input  pc,
    input  pc_plus4,
    input  misalign
  );

  // Fetch stage side.
  modport slave (
    input  fetch_req,
    input  redirect,
    input  redirect_target,
    input  rom_data,
    output fetch_ack,
    output rom_addr,
    output ir,
    output pc,
    output pc_plus4,
    output misalign
  );

endinterface : instr_fetch_if

// File: rtl/instr_fetch_pc.sv
// Fetch program counter: redirect load with word alignment, increment by 4,
// and a one-cycle pulse flagging a misaligned redirect target.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 17,
  parameter int RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_target,
  input  logic              i_incr,
  output logic [ADDR_W-1:0] o_pc_fetch,
  output logic              o_misalign_set
);

  logic [ADDR_W-1:0] r_pc_fetch;
  logic [ADDR_W-1:0] w_target_aligned;
  logic [ADDR_W-1:0] w_pc_next;

  // Low two bits are dropped so the ROM is always addressed on a word boundary.
  assign w_target_aligned = {i_target[ADDR_W-1:2], 2'b00};

  // Next-address select: a redirect load beats the sequential increment.
  always_comb begin
    w_pc_next = r_pc_fetch;
    if (i_load) begin
      w_pc_next = w_target_aligned;
    end else if (i_incr) begin
      w_pc_next = r_pc_fetch + ADDR_W'(4);
    end else begin
      w_pc_next = r_pc_fetch;
    end
  end

  // Fetch address register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc_fetch <= ADDR_W'(RESET_PC);
    end else begin
      r_pc_fetch <= w_pc_next;
    end
  end

  assign o_pc_fetch     = r_pc_fetch;
  assign o_misalign_set = i_load & (|i_target[1:0]);

endmodule : fetch_pc

// File: rtl/instr_fetch.sv
// Instruction fetch stage: request/ack FSM, IR and PC capture, sticky misalign flag.
// The ROM is assumed to return data one cycle after the address is presented.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 17,
  parameter int RESET_PC = 0
) (
  input  logic          clock,
  input  logic          reset_n,
  instr_fetch_if.slave  bus
);

  fetch_state_e        r_state;
  fetch_state_e        w_state_next;
  logic                w_load;
  logic                w_incr;
  logic                w_capture;
  logic                w_misalign_set;
  logic [ADDR_W-1:0]   w_pc_fetch;
  logic [INSTR_W-1:0]  r_ir;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_ack;
  logic                r_misalign;

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clock          (clock),
    .reset_n        (reset_n),
    .i_load         (w_load),
    .i_target       (bus.redirect_target),
    .i_incr         (w_incr),
    .o_pc_fetch     (w_pc_fetch),
    .o_misalign_set (w_misalign_set)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control decode; a redirect always wins and aborts a fetch in flight.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_incr       = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.redirect) begin
          w_load       = 1'b1;
          w_state_next = IDLE;
        end else if (bus.fetch_req) begin
          w_state_next = WAIT;
        end else begin
          w_state_next = IDLE;
        end
      end
      WAIT: begin
        if (bus.redirect) begin
          w_load       = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_capture    = 1'b1;
          w_incr       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Instruction register and its byte address, updated only on a completed fetch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ir <= NOP_INSTR;
      r_pc <= ADDR_W'(RESET_PC);
    end else if (w_capture) begin
      r_ir <= bus.rom_data;
      r_pc <= w_pc_fetch;
    end else begin
      r_ir <= r_ir;
      r_pc <= r_pc;
    end
  end

  // Single-cycle ack, raised the cycle after the ROM word is captured.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= w_capture;
    end
  end

  // Sticky misaligned-redirect flag; only reset clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= r_misalign | w_misalign_set;
    end
  end

  assign bus.rom_addr  = w_pc_fetch;
  assign bus.ir        = r_ir;
  assign bus.pc        = r_pc;
  assign bus.pc_plus4  = r_pc + ADDR_W'(4);
  assign bus.fetch_ack = r_ack;
  assign bus.misalign  = r_misalign;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a one-cycle-latency ROM model.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int ADDR_W = 17;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [31:0] rom [0:32767];

  instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (0)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: word for the presented address appears after the next edge.
  always @(posedge clk) begin
    bus.rom_data <= rom[bus.rom_addr[16:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 32768; i++) rom[i] = 32'hC0DE_0000 | i;
    rom[0] = 32'h0020_0093;
    rom[1] = 32'h0030_0113;

    rst_n               = 1'b0;
    bus.fetch_req       = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = 17'h0_0000;
    bus.rom_data        = 32'h0000_0000;
    step();
    step();

    // Reset state
    chk("rst_ir",       bus.ir,               32'h0000_0013);
    chk("rst_pc",       32'(bus.pc),          32'h0000_0000);
    chk("rst_ack",      32'(bus.fetch_ack),   32'h0000_0000);
    chk("rst_misalign", 32'(bus.misalign),    32'h0000_0000);
    chk("rst_rom_addr", 32'(bus.rom_addr),    32'h0000_0000);
    chk("rst_pc_plus4", 32'(bus.pc_plus4),    32'h0000_0004);

    // Back-to-back fetches with fetch_req held high (cycle T0 = release)
    rst_n         = 1'b1;
    bus.fetch_req = 1'b1;
    step(); // T1
    chk("seq_ack_t1",   32'(bus.fetch_ack),   32'h0000_0000);
    step(); // T2
    chk("seq_ack_t2",   32'(bus.fetch_ack),   32'h0000_0001);
    chk("seq_ir0",      bus.ir,               32'h0020_0093);
    chk("seq_pc0",      32'(bus.pc),          32'h0000_0000);
    chk("seq_pp4_0",    32'(bus.pc_plus4),    32'h0000_0004);
    chk("seq_rom_t2",   32'(bus.rom_addr),    32'h0000_0004);
    step(); // T3
    chk("seq_ack_t3",   32'(bus.fetch_ack),   32'h0000_0000);
    chk("seq_ir_hold",  bus.ir,               32'h0020_0093);
    step(); // T4
    chk("seq_ack_t4",   32'(bus.fetch_ack),   32'h0000_0001);
    chk("seq_ir1",      bus.ir,               32'h0030_0113);
    chk("seq_pc1",      32'(bus.pc),          32'h0000_0004);
    chk("seq_pp4_1",    32'(bus.pc_plus4),    32'h0000_0008);

    // Redirect in IDLE together with fetch_req: not accepted that cycle
    bus.redirect        = 1'b1;
    bus.redirect_target = 17'h0_0020;
    step(); // T5
    chk("rdi_ack_t5",   32'(bus.fetch_ack),   32'h0000_0000);
    chk("rdi_rom_addr", 32'(bus.rom_addr),    32'h0000_0020);
    chk("rdi_pc_hold",  32'(bus.pc),          32'h0000_0004);
    bus.redirect = 1'b0;
    step(); // T6: WAIT
    chk("rdi_ack_t6",   32'(bus.fetch_ack),   32'h0000_0000);
    step(); // T7
    chk("rdi_ack_t7",   32'(bus.fetch_ack),   32'h0000_0001);
    chk("rdi_pc",       32'(bus.pc),          32'h0000_0020);
    chk("rdi_ir",       bus.ir,               32'hC0DE_0008);

    // Redirect during WAIT aborts the fetch
    step(); // T8: WAIT
    chk("rdw_ack_t8",   32'(bus.fetch_ack),   32'h0000_0000);
    bus.redirect        = 1'b1;
    bus.redirect_target = 17'h0_0010;
    step(); // T9
    chk("rdw_no_ack",   32'(bus.fetch_ack),   32'h0000_0000);
    chk("rdw_ir_keep",  bus.ir,               32'hC0DE_0008);
    chk("rdw_pc_keep",  32'(bus.pc),          32'h0000_0020);
    chk("rdw_rom_addr", 32'(bus.rom_addr),    32'h0000_0010);
    bus.redirect = 1'b0;
    step(); // T10
    step(); // T11
    chk("rdw_ack",      32'(bus.fetch_ack),   32'h0000_0001);
    chk("rdw_pc",       32'(bus.pc),          32'h0000_0010);
    chk("rdw_ir",       bus.ir,               32'hC0DE_0004);
    chk("rdw_misalign", 32'(bus.misalign),    32'h0000_0000);

    // Misaligned redirect target
    bus.redirect        = 1'b1;
    bus.redirect_target = 17'h0_0022;
    step(); // T12
    chk("mis_flag",     32'(bus.misalign),    32'h0000_0001);
    chk("mis_rom_addr", 32'(bus.rom_addr),    32'h0000_0020);
    bus.redirect = 1'b0;
    step(); // T13
    step(); // T14
    chk("mis_ack",      32'(bus.fetch_ack),   32'h0000_0001);
    chk("mis_pc",       32'(bus.pc),          32'h0000_0020);
    chk("mis_sticky",   32'(bus.misalign),    32'h0000_0001);

    // Wrap-around at the top of the address space
    bus.redirect        = 1'b1;
    bus.redirect_target = 17'h1_FFFC;
    step(); // T15
    chk("wrap_rom_top", 32'(bus.rom_addr),    32'h0001_FFFC);
    bus.redirect = 1'b0;
    step(); // T16
    step(); // T17
    chk("wrap_ack",     32'(bus.fetch_ack),   32'h0000_0001);
    chk("wrap_pc",      32'(bus.pc),          32'h0001_FFFC);
    chk("wrap_pp4",     32'(bus.pc_plus4),    32'h0000_0000);
    chk("wrap_ir",      bus.ir,               32'hC0DE_7FFF);
    chk("wrap_rom_nxt", 32'(bus.rom_addr),    32'h0000_0000);

    // Reset asserted while in WAIT
    step(); // T18: WAIT
    chk("rw_ack_t18",   32'(bus.fetch_ack),   32'h0000_0000);
    rst_n = 1'b0;
    #1;
    chk("rw_ir",        bus.ir,               32'h0000_0013);
    chk("rw_pc",        32'(bus.pc),          32'h0000_0000);
    chk("rw_ack",       32'(bus.fetch_ack),   32'h0000_0000);
    chk("rw_misalign",  32'(bus.misalign),    32'h0000_0000);
    chk("rw_rom_addr",  32'(bus.rom_addr),    32'h0000_0000);
    bus.fetch_req = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rw_idle_ack", 32'(bus.fetch_ack),  32'h0000_0000);
    end
    bus.fetch_req = 1'b1;
    step();
    chk("rw_req_t1",    32'(bus.fetch_ack),   32'h0000_0000);
    step();
    chk("rw_req_ack",   32'(bus.fetch_ack),   32'h0000_0001);
    chk("rw_req_pc",    32'(bus.pc),          32'h0000_0000);
    chk("rw_req_ir",    bus.ir,               32'h0020_0093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_instr_fetch
